// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: picks the highest-priority event in IDLE, then
// walks FLUSH -> REDIRECT to squash the pipeline and steer the PC.
module exc_ctrl #(
    parameter int          NIRQ     = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic            exc_ill,
    input  logic            exc_ovf,
    input  logic            exc_sys,
    input  logic            is_rfe,
    input  logic [31:0]     pc_ex,
    input  logic            ie,
    input  logic            s_u,
    output logic            exception,
    output logic            rfe,
    output logic            flush,
    output logic            pc_sel,
    output logic [31:0]     pc_tgt,
    output logic [7:0]      cause,
    output logic [31:0]     epc,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rfeKind_q, rfeKind_d;
    logic [7:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pcTgt_q, pcTgt_d;

    logic [7:0]  irqCode;
    logic        irqTaken;

    // Lowest-numbered asserted request line wins among interrupts.
    always_comb begin
        irqCode = 8'h10;
        for (int n = NIRQ - 1; n >= 0; n--) begin
            if (irq[n]) begin
                irqCode = 8'h10 + 8'(n);
            end
        end
        irqTaken = ie && (|irq);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rfeKind_q <= 1'b0;
            cause_q   <= 8'h00;
            epc_q     <= 32'h0;
            pcTgt_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            rfeKind_q <= rfeKind_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            pcTgt_q   <= pcTgt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rfeKind_d = rfeKind_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        pcTgt_d   = pcTgt_q;
        exception = 1'b0;
        rfe       = 1'b0;
        flush     = 1'b0;
        pc_sel    = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // An interrupt outranks a supervisor rfe so the rfe is re-executed later.
                if (exc_ill || (is_rfe && !s_u)) begin
                    state_d   = FLUSH;
                    rfeKind_d = 1'b0;
                    cause_d   = 8'h0A;
                    epc_d     = pc_ex;
                end else if (exc_ovf) begin
                    state_d   = FLUSH;
                    rfeKind_d = 1'b0;
                    cause_d   = 8'h0C;
                    epc_d     = pc_ex;
                end else if (exc_sys) begin
                    state_d   = FLUSH;
                    rfeKind_d = 1'b0;
                    cause_d   = 8'h08;
                    epc_d     = pc_ex;
                end else if (irqTaken) begin
                    state_d   = FLUSH;
                    rfeKind_d = 1'b0;
                    cause_d   = irqCode;
                    epc_d     = pc_ex;
                end else if (is_rfe) begin
                    state_d   = FLUSH;
                    rfeKind_d = 1'b1;
                end
            end
            FLUSH: begin
                exception = !rfeKind_q;
                rfe       = rfeKind_q;
                flush     = 1'b1;
                busy      = 1'b1;
                state_d   = REDIRECT;
                pcTgt_d   = rfeKind_q ? epc_q : VEC_BASE;
            end
            REDIRECT: begin
                pc_sel  = 1'b1;
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc_tgt = pcTgt_q;
    assign cause  = cause_q;
    assign epc    = epc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed events push expected pulses,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_exc_ctrl;

    localparam int NIRQ = 4;
    localparam int K_EXC = 0;
    localparam int K_RFE = 1;
    localparam int K_TGT = 2;

    typedef struct {
        int          kind;
        logic [7:0]  cause;
        logic [31:0] addr;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [NIRQ-1:0] irq;
    logic            exc_ill, exc_ovf, exc_sys, is_rfe, ie, s_u;
    logic [31:0]     pc_ex;
    logic            exception, rfe, flush, pc_sel, busy;
    logic [31:0]     pc_tgt, epc;
    logic [7:0]      cause;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    exc_ctrl #(.NIRQ(NIRQ), .VEC_BASE(32'h0000_0080)) dut (
        .clk(clk), .rst(rst), .irq(irq),
        .exc_ill(exc_ill), .exc_ovf(exc_ovf), .exc_sys(exc_sys),
        .is_rfe(is_rfe), .pc_ex(pc_ex), .ie(ie), .s_u(s_u),
        .exception(exception), .rfe(rfe), .flush(flush), .pc_sel(pc_sel),
        .pc_tgt(pc_tgt), .cause(cause), .epc(epc), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int k, input logic [7:0] c, input logic [31:0] a);
        exp_t e;
        e.kind = k; e.cause = c; e.addr = a;
        return e;
    endfunction

    // Monitor: every pulse the DUT emits must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (exception || rfe || pc_sel) begin
            checkOutput("exc_rfe_exclusive", {31'b0, exception & rfe}, 32'h0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {29'b0, exception, rfe, pc_sel}, 32'h0);
            end else begin
                e = sb.pop_front();
                if (exception || rfe) begin
                    checkOutput("pulse_kind", {31'b0, rfe}, (e.kind == K_RFE) ? 32'h1 : 32'h0);
                    checkOutput("expect_flush_pulse", (e.kind == K_TGT) ? 32'h0 : 32'h1, 32'h1);
                    checkOutput("flush", {31'b0, flush}, 32'h1);
                    checkOutput("cause", {24'b0, cause}, {24'b0, e.cause});
                    checkOutput("epc", epc, e.addr);
                end else begin
                    checkOutput("expect_redirect", (e.kind == K_TGT) ? 32'h1 : 32'h0, 32'h1);
                    checkOutput("redirect_flush_low", {31'b0, flush}, 32'h0);
                    checkOutput("pc_tgt", pc_tgt, e.addr);
                end
            end
        end
    end

    task automatic clearInputs();
        irq = '0; exc_ill = 0; exc_ovf = 0; exc_sys = 0; is_rfe = 0;
        ie = 0; s_u = 0; pc_ex = 32'h0;
    endtask

    // Present one cycle of stimulus, sampled on the next rising edge.
    task automatic applyStimulus(input logic [NIRQ-1:0] vIrq, input logic vIll, input logic vOvf,
                                 input logic vSys, input logic vRfe, input logic vIe,
                                 input logic vSu, input logic [31:0] vPc);
        @(negedge clk);
        irq = vIrq; exc_ill = vIll; exc_ovf = vOvf; exc_sys = vSys;
        is_rfe = vRfe; ie = vIe; s_u = vSu; pc_ex = vPc;
        @(posedge clk);
        #1 clearInputs();
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drained", sb.size(), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        clearInputs();
        rst = 1'b0;
        #12;
        checkOutput("rst_pulses", {27'b0, exception, rfe, flush, pc_sel, busy}, 32'h0);
        checkOutput("rst_pc_tgt", pc_tgt, 32'h0);
        checkOutput("rst_epc", epc, 32'h0);
        checkOutput("rst_cause", {24'b0, cause}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // syscall
        sb.push_back(mk(K_EXC, 8'h08, 32'h0000_1000));
        sb.push_back(mk(K_TGT, 8'h00, 32'h0000_0080));
        applyStimulus(4'b0000, 0, 0, 1, 0, 0, 1, 32'h0000_1000);
        waitDrain();

        // illegal beats overflow and interrupts
        sb.push_back(mk(K_EXC, 8'h0A, 32'h0000_1004));
        sb.push_back(mk(K_TGT, 8'h00, 32'h0000_0080));
        applyStimulus(4'b0110, 1, 1, 0, 0, 1, 0, 32'h0000_1004);
        waitDrain();

        // interrupt line 2
        sb.push_back(mk(K_EXC, 8'h12, 32'h0000_0200));
        sb.push_back(mk(K_TGT, 8'h00, 32'h0000_0080));
        applyStimulus(4'b0100, 0, 0, 0, 0, 1, 0, 32'h0000_0200);
        waitDrain();

        // masked interrupt: no pulse, never busy
        @(negedge clk);
        irq = 4'b0100; ie = 0; pc_ex = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("masked_irq_busy", {31'b0, busy}, 32'h0);
        end
        clearInputs();

        // supervisor rfe returns to saved epc, epc/cause untouched
        sb.push_back(mk(K_RFE, 8'h12, 32'h0000_0200));
        sb.push_back(mk(K_TGT, 8'h00, 32'h0000_0200));
        applyStimulus(4'b0000, 0, 0, 0, 1, 0, 1, 32'h0000_0999);
        waitDrain();

        // user-mode rfe is privileged -> illegal
        sb.push_back(mk(K_EXC, 8'h0A, 32'h0000_0300));
        sb.push_back(mk(K_TGT, 8'h00, 32'h0000_0080));
        applyStimulus(4'b0000, 0, 0, 0, 1, 0, 0, 32'h0000_0300);
        waitDrain();

        // interrupt wins over supervisor rfe
        sb.push_back(mk(K_EXC, 8'h10, 32'h0000_0400));
        sb.push_back(mk(K_TGT, 8'h00, 32'h0000_0080));
        applyStimulus(4'b0001, 0, 0, 0, 1, 1, 1, 32'h0000_0400);
        waitDrain();

        // overflow over syscall, highest irq line
        sb.push_back(mk(K_EXC, 8'h0C, 32'h0000_0500));
        sb.push_back(mk(K_TGT, 8'h00, 32'h0000_0080));
        applyStimulus(4'b1000, 0, 1, 1, 0, 1, 0, 32'h0000_0500);
        waitDrain();
        sb.push_back(mk(K_EXC, 8'h13, 32'h0000_0504));
        sb.push_back(mk(K_TGT, 8'h00, 32'h0000_0080));
        applyStimulus(4'b1000, 0, 0, 0, 0, 1, 0, 32'h0000_0504);
        waitDrain();

        // reset during FLUSH: exception pulse seen, redirect must never come
        sb.push_back(mk(K_EXC, 8'h08, 32'h0000_0600));
        applyStimulus(4'b0000, 0, 0, 1, 0, 0, 1, 32'h0000_0600);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("midrst_pulses", {27'b0, exception, rfe, flush, pc_sel, busy}, 32'h0);
        checkOutput("midrst_epc", epc, 32'h0);
        checkOutput("midrst_cause", {24'b0, cause}, 32'h0);
        checkOutput("midrst_pc_tgt", pc_tgt, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("postrst_busy", {31'b0, busy}, 32'h0);
        checkOutput("postrst_queue", sb.size(), 32'h0);

        // first edge after release evaluates normally
        sb.push_back(mk(K_EXC, 8'h08, 32'h0000_0700));
        sb.push_back(mk(K_TGT, 8'h00, 32'h0000_0080));
        applyStimulus(4'b0000, 0, 0, 1, 0, 0, 1, 32'h0000_0700);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter: NIRQ, 4, number of external interrupt request lines (1..8).
REQ-002 Parameter: VEC_BASE, 32'h0000_0080, exception vector address.
REQ-003 Port: clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: irq  in  NIRQ  level-sensitive external interrupt requests.
REQ-006 Port: exc_ill  in  1  illegal instruction in execute stage.
REQ-007 Port: exc_ovf  in  1  arithmetic overflow in execute stage.
REQ-008 Port: exc_sys  in  1  syscall instruction in execute stage.
REQ-009 Port: is_rfe  in  1  decoded rfe instruction in execute stage.
REQ-010 Port: pc_ex  in  32  PC of the execute-stage instruction.
REQ-011 Port: ie  in  1  interrupt enable from the status register.
REQ-012 Port: s_u  in  1  current mode from the status register; 1 = supervisor.
REQ-013 Port: exception  out  1  one-cycle pulse to the status register: enter exception.
REQ-014 Port: rfe  out  1  one-cycle pulse to the status register: return from exception.
REQ-015 Port: flush  out  1  one-cycle pulse: squash fetch/decode/execute.
REQ-016 Port: pc_sel  out  1  one-cycle pulse: PC loads pc_tgt.
REQ-017 Port: pc_tgt  out  32  redirect target; valid while pc_sel=1.
REQ-018 Port: cause  out  8  cause code of the last taken exception.
REQ-019 Port: epc  out  32  saved PC of the last taken exception.
REQ-020 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states are IDLE, FLUSH and REDIRECT: IDLE->FLUSH on a taken event, FLUSH->REDIRECT unconditionally, REDIRECT->IDLE unconditionally.
REQ-022 Events are evaluated only in IDLE; all inputs are ignored in FLUSH and REDIRECT.
REQ-023 Event priority in IDLE: exc_ill, then privileged rfe (is_rfe with s_u=0), then exc_ovf, then exc_sys, then interrupt (ie=1 and any irq bit set), then rfe (is_rfe with s_u=1).
REQ-024 Cause codes: exc_ill = 8'h0A; privileged rfe = 8'h0A; exc_ovf = 8'h0C; exc_sys = 8'h08; irq[n] = 8'h10+n, where n is the lowest-numbered asserted bit.
REQ-025 An exception taken at edge T sets exception=1, flush=1, epc<=pc_ex and cause<=code for the cycle after T, with state FLUSH.
REQ-026 At edge T+1 the block sets pc_sel=1 and pc_tgt=VEC_BASE for one cycle, with state REDIRECT.
REQ-027 An rfe taken at edge T sets rfe=1 and flush=1 for the cycle after T; at T+1 it sets pc_sel=1 and pc_tgt=epc; epc and cause are unchanged.
REQ-028 exception and rfe are never high in the same cycle; every output pulse is exactly one cycle wide.
REQ-029 For interrupts, epc = pc_ex of the interrupted instruction, which has not executed and is re-executed after rfe.
REQ-030 An interrupt coinciding with is_rfe in supervisor mode wins; the rfe is not performed and epc=pc_ex of the rfe.
REQ-031 irq with ie=0 is not taken and is not latched; an irq still held after rfe restores ie=1 is taken in the first IDLE cycle thereafter.
REQ-032 The status register sees exception at T+1 and updates ie/s_u by T+2; busy prevents re-entry on the stale ie value.
REQ-033 If no event is present in IDLE, all pulses are 0 and cause/epc/pc_tgt hold their values.

Reset
REQ-034 While rst=0: state=IDLE; exception, rfe, flush, pc_sel, busy = 0; pc_tgt, epc = 32'h0; cause = 8'h00.
REQ-035 Reset asserted mid-sequence (FLUSH or REDIRECT) immediately clears state and all outputs; no pulse is emitted after release until a new event occurs.
REQ-036 After reset release, the first rising edge evaluates events normally.

Verification
REQ-037 exc_sys=1, pc_ex=32'h0000_1000 in IDLE -> next cycle exception=1, flush=1, cause=8'h08, epc=32'h0000_1000; following cycle pc_sel=1, pc_tgt=32'h0000_0080; then IDLE.
REQ-038 exc_ill=1, exc_ovf=1, irq=4'b0110, ie=1 simultaneously -> cause=8'h0A only, with a single exception pulse.
REQ-039 irq=4'b0100, ie=1, pc_ex=32'h200 -> cause=8'h12, epc=32'h200; repeating the stimulus with ie=0 -> no pulse, busy stays 0.
REQ-040 is_rfe=1, s_u=1, epc=32'h200 -> rfe=1 and flush=1, then pc_sel=1 with pc_tgt=32'h200; is_rfe=1 with s_u=0 -> exception with cause=8'h0A and no rfe pulse.
REQ-041 is_rfe=1, s_u=1 together with irq=4'b0001, ie=1 -> exception with cause=8'h10 and no rfe pulse.
REQ-042 rst asserted during FLUSH -> pc_sel never pulses, all outputs read 0, and state returns to IDLE after release.
